// File: rtl/game_pkg.sv
// Shared types and screen geometry for the dodge game controller.
// GAME_CTRL_RANDOM_SPAWN_EN selects LFSR-based enemy spawn columns.
package game_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;

  localparam logic [15:0] X_MIN      = 16'd145;
  localparam logic [15:0] X_MAX      = 16'd783;
  localparam logic [15:0] Y_MIN      = 16'd36;
  localparam logic [15:0] Y_MAX      = 16'd514;
  localparam logic [15:0] SPRITE_W   = 16'd50;
  localparam logic [15:0] SPRITE_H   = 16'd20;
  localparam logic [15:0] ROW_TOP    = 16'd440;
  localparam logic [15:0] ROW_BOT    = 16'd460;
  localparam logic [15:0] X_START    = 16'd400;
  localparam logic [15:0] X_RIGHT    = X_MAX - SPRITE_W;
  localparam logic [15:0] SPAWN_SPAN = X_RIGHT - X_MIN + 16'd1;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  function automatic logic [16:0] ext17(input logic [15:0] v);
    return {1'b0, v};
  endfunction

  // A 10-bit value is below 2*589, so one conditional subtract is a full modulo.
  function automatic logic [15:0] spawnFromLfsr(input logic [15:0] s);
    logic [15:0] low;
    low = {6'd0, s[9:0]};
    if (low >= SPAWN_SPAN) low = low - SPAWN_SPAN;
    return X_MIN + low;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11) used for enemy spawn columns.
// Only built when GAME_CTRL_RANDOM_SPAWN_EN is defined.
`ifdef GAME_CTRL_RANDOM_SPAWN_EN
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LFSR_SEED;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule
`endif

// File: rtl/game_ctrl.sv
// Frame-tick driven game controller: player dodges a falling enemy.
// GAME_CTRL_RANDOM_SPAWN_EN enables random spawn columns via lfsr16.
module game_ctrl
  import game_pkg::*;
#(
  parameter int PLAYER_STEP = 4,
  parameter int ENEMY_STEP  = 2,
  parameter int LIVES       = 3,
  parameter int HIT_FRAMES  = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  output logic [15:0] x_player,
  output logic [15:0] x_enemy,
  output logic [15:0] y_enemy,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        led
);

  localparam logic [16:0] P_STEP     = 17'(PLAYER_STEP);
  localparam logic [16:0] E_STEP     = 17'(ENEMY_STEP);
  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
  localparam logic [15:0] HIT_LOAD   = 16'(HIT_FRAMES);

  state_t      state_q, state_d;
  logic [15:0] xPlayer_q, xPlayer_d;
  logic [15:0] xEnemy_q, xEnemy_d;
  logic [15:0] yEnemy_q, yEnemy_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [15:0] hitCnt_q, hitCnt_d;

  logic [16:0] xp, xe, ye, xLeft, xRight, yNext;
  logic        collide;
  logic [15:0] spawnX;

`ifdef GAME_CTRL_RANDOM_SPAWN_EN
  logic [15:0] lfsrState;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .en_i    (frame_tick && (state_q == PLAY)),
    .state_o (lfsrState)
  );

  assign spawnX = spawnFromLfsr(lfsrState);
`else
  assign spawnX = X_START;
`endif

  // Geometry is evaluated in 17 bits on the pre-update positions.
  assign xp      = ext17(xPlayer_q);
  assign xe      = ext17(xEnemy_q);
  assign ye      = ext17(yEnemy_q);
  assign xLeft   = (xp < ext17(X_MIN) + P_STEP) ? ext17(X_MIN) : xp - P_STEP;
  assign xRight  = (xp + P_STEP > ext17(X_RIGHT)) ? ext17(X_RIGHT) : xp + P_STEP;
  assign yNext   = ye + E_STEP;
  assign collide = (ye + ext17(SPRITE_H) > ext17(ROW_TOP)) && (ye < ext17(ROW_BOT)) &&
                   (xe < xp + ext17(SPRITE_W)) && (xe + ext17(SPRITE_W) > xp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      xPlayer_q <= X_START;
      xEnemy_q  <= X_START;
      yEnemy_q  <= Y_MIN;
      score_q   <= 8'd0;
      lives_q   <= LIVES_INIT;
      hitCnt_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      xPlayer_q <= xPlayer_d;
      xEnemy_q  <= xEnemy_d;
      yEnemy_q  <= yEnemy_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      hitCnt_q  <= hitCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    xPlayer_d = xPlayer_q;
    xEnemy_d  = xEnemy_q;
    yEnemy_d  = yEnemy_q;
    score_d   = score_q;
    lives_d   = lives_q;
    hitCnt_d  = hitCnt_q;
    if (frame_tick) begin
      unique case (state_q)
        IDLE: if (btn_start) state_d = PLAY;
        PLAY: begin
          if (collide) begin
            lives_d  = lives_q - 2'd1;
            hitCnt_d = HIT_LOAD;
            state_d  = HIT;
          end else begin
            if (btn_left && !btn_right)      xPlayer_d = 16'(xLeft);
            else if (btn_right && !btn_left) xPlayer_d = 16'(xRight);
            if (yNext >= ext17(Y_MAX)) begin
              yEnemy_d = Y_MIN;
              xEnemy_d = spawnX;
              if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end else begin
              yEnemy_d = 16'(yNext);
            end
          end
        end
        HIT: begin
          // Exit on the tick that counts the counter down to zero.
          if (hitCnt_q <= 16'd1) begin
            hitCnt_d = 16'd0;
            if (lives_q == 2'd0) begin
              state_d = OVER;
            end else begin
              yEnemy_d = Y_MIN;
              xEnemy_d = spawnX;
              state_d  = PLAY;
            end
          end else begin
            hitCnt_d = hitCnt_q - 16'd1;
          end
        end
        OVER: begin
          if (btn_start) begin
            state_d   = IDLE;
            xPlayer_d = X_START;
            xEnemy_d  = X_START;
            yEnemy_d  = Y_MIN;
            score_d   = 8'd0;
            lives_d   = LIVES_INIT;
            hitCnt_d  = 16'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    led = 1'b0;
    if (state_q == OVER) led = 1'b1;
  end

  assign x_player = xPlayer_q;
  assign x_enemy  = xEnemy_q;
  assign y_enemy  = yEnemy_q;
  assign score    = score_q;
  assign lives    = lives_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter PLAYER_STEP, default 4, player x pixels moved per frame.
REQ-002 SHALL have parameter ENEMY_STEP, default 2, enemy y pixels moved per frame.
REQ-003 SHALL have parameter LIVES, default 3, lives granted at game start (1..3).
REQ-004 SHALL have parameter HIT_FRAMES, default 60, frames frozen after a collision.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 frame_tick  input  1  one-cycle pulse, once per video frame (start of vertical blank).
REQ-008 btn_left, btn_right, btn_start  input  1 each  synchronised, level-sensitive buttons.
REQ-009 x_player  output  16  player left edge; player row is fixed at y 440..460.
REQ-010 x_enemy, y_enemy  output  16 each  enemy left edge / top edge (enemy 50x20).
REQ-011 score  output  8  enemies dodged; lives  output  2  remaining lives.
REQ-012 led  output  1  high while in OVER state.

Function
REQ-013 SHALL implement FSM IDLE, PLAY, HIT, OVER; all transitions except reset occur only on cycles with frame_tick=1.
REQ-014 IDLE: x_player=400, x_enemy=400, y_enemy=36, score=0, lives=LIVES; btn_start=1 on tick -> PLAY.
REQ-015 PLAY, per tick: x_player -= PLAYER_STEP if only btn_left, += if only btn_right, unchanged if both or neither.
REQ-016 x_player SHALL clamp to [145, 733]; a step crossing a bound lands exactly on the bound.
REQ-017 PLAY, per tick: y_enemy += ENEMY_STEP; if the new value >= 514, y_enemy=36, x_enemy=next spawn x, score+=1 (saturates at 255).
REQ-018 Collision SHALL be y_enemy+20 > 440 and y_enemy < 460 and x_enemy < x_player+50 and x_enemy+50 > x_player, evaluated on pre-update positions at each PLAY tick; all arithmetic in 17 bits, no wrap.
REQ-019 Collision takes priority over movement and respawn on that tick: positions hold, lives -= 1, hit counter loads HIT_FRAMES, -> HIT.
REQ-020 HIT: positions frozen; counter decrements per tick; at 0, if lives=0 -> OVER, else y_enemy=36, x_enemy=next spawn x, -> PLAY.
REQ-021 OVER: positions and score hold; led=1; btn_start on tick -> IDLE.
REQ-022 Outputs SHALL be registered and change exactly one clk after the frame_tick cycle; stable between ticks.
REQ-023 btn_start outside IDLE/OVER SHALL be ignored; frame_tick absent -> no state change.

Reset
REQ-024 reset=0 SHALL immediately force IDLE with REQ-014 values, led=0, hit counter=0, spawn generator to seed 16'hACE1, regardless of state or pending tick.
REQ-025 Deassertion SHALL take effect on the next clk edge; no tick is lost or replayed.

Configuration
REQ-026 Macro GAME_CTRL_RANDOM_SPAWN_EN defined: next spawn x = 145 + (lfsr[9:0] mod 589), LFSR advanced once per tick in PLAY.
REQ-027 Macro undefined: next spawn x is always 400; LFSR logic absent.

Structure
REQ-028 Package game_pkg SHALL hold the state enum, screen bounds (145, 783, 36, 514), sprite sizes (50x20), player row (440/460), LFSR seed.
REQ-029 Sub-module lfsr16 (16-bit Galois, taps 16,14,13,11, enable input) SHALL be instantiated only under the macro.

Verification
REQ-030 Reset mid-PLAY (score=5, y_enemy=200) -> next cycle IDLE, score=0, lives=3, x_player=400, y_enemy=36, led=0.
REQ-031 PLAY, x_player=147, btn_left held 1 tick -> x_player=145; further ticks stay 145; both buttons -> no move.
REQ-032 y_enemy=512, no collision, tick -> y_enemy=36, score+1; score=255 stays 255.
REQ-033 x_player=400, x_enemy=440, y_enemy=425 tick -> HIT, lives 3->2, positions held 60 ticks, then PLAY with y_enemy=36.
REQ-034 lives=1, collision -> HIT, after 60 ticks OVER, led=1; btn_start tick -> IDLE, led=0.
REQ-035 Edge-touch x_enemy=x_player+50 -> no collision; without macro every respawn x_enemy=400, with macro first spawn matches lfsr16 model from 16'hACE1.
